cr_axi4s_slv_su: RTL and testbench
==================================

CR_AXI4S_SLV_SU -- requirements
Module: cr_axi4s_slv_su

Interface
REQ-001 SHALL have parameter BEAT_CNT_W, default 16, width of the per-frame beat counter.
REQ-002 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port axi4s_ib_in  input  axi4s_su_dp_bus_t  inbound AXI4-S beat (tvalid, tlast, payload fields).
REQ-005 SHALL have port axi4s_ib_out  output  axi4s_dp_rdy_t  inbound tready.
REQ-006 SHALL have port axi4s_slv_wr  output  1  write strobe to downstream FIFO.
REQ-007 SHALL have port axi4s_slv_data  output  axi4s_su_dp_bus_t  beat written to FIFO.
REQ-008 SHALL have port axi4s_slv_full  input  1  downstream FIFO full.
REQ-009 SHALL have port frame_done  output  1  one-cycle pulse when a tlast beat is written to FIFO.
REQ-010 SHALL have port frame_beats  output  BEAT_CNT_W  beat count of completed frame, valid with frame_done.

Function
REQ-011 SHALL hold two registered entries: main (M) and skid (S), each a full axi4s_su_dp_bus_t plus valid.
REQ-012 SHALL drive axi4s_ib_out.tready = ~S.valid, directly from a flop (no combinational path from axi4s_slv_full or axi4s_ib_in).
REQ-013 SHALL accept a beat when axi4s_ib_in.tvalid & tready; tvalid without tready SHALL be ignored (source holds).
REQ-014 SHALL assert axi4s_slv_wr = M.valid & ~axi4s_slv_full, with axi4s_slv_data = M; wr SHALL never assert while full.
REQ-015 SHALL implement occupancy states EMPTY (M,S invalid), ONE (M valid), TWO (M,S valid).
REQ-016 EMPTY: accept -> ONE, beat into M; minimum latency accept-to-wr = 1 cycle.
REQ-017 ONE: accept & wr -> ONE, new beat into M; accept & ~wr -> TWO, beat into S; ~accept & wr -> EMPTY.
REQ-018 TWO: no accept possible; wr -> ONE, S moves into M, S cleared; ~wr -> hold.
REQ-019 SHALL preserve beat order exactly; no beat dropped or duplicated under any full/tvalid pattern.
REQ-020 SHALL clear invalid entries to all-zero so axi4s_slv_data is zero when M.valid = 0.
REQ-021 SHALL count beats written in the current frame; on tlast write pulse frame_done and present count including the tlast beat, then restart count at 0 next cycle.
REQ-022 Beat counter SHALL saturate at all-ones, never wrap; frame_beats reports saturated value.
REQ-023 Single-beat frame (tlast on first beat) SHALL report frame_beats = 1.
REQ-024 frame_done/frame_beats SHALL be registered one cycle after the tlast wr cycle; frame_beats holds until next frame_done.

Reset
REQ-025 SHALL, on rst_n low, asynchronously clear M, S, beat counter, frame_beats to 0, frame_done to 0, state to EMPTY.
REQ-026 SHALL drive tready = 1 and axi4s_slv_wr = 0 one cycle out of reset (tready from S.valid = 0).
REQ-027 Reset mid-frame SHALL discard buffered beats and the partial count; no frame_done for the aborted frame.

Structure
REQ-028 axi4s_su_dp_bus_t and axi4s_dp_rdy_t SHALL come from cr_structs; no new package types.
REQ-029 SHALL be a single flat module; no sub-module.

Verification
REQ-030 Reset release, tvalid=0 -> tready=1, wr=0, frame_done=0, data all-zero.
REQ-031 Back-to-back 4-beat frame, full=0 -> wr on 4 consecutive cycles each 1 cycle after accept, frame_done pulse with frame_beats=4.
REQ-032 full=1 while streaming -> exactly 2 beats accepted, then tready=0; release full -> beats written in order, tready=1 one cycle after first wr.
REQ-033 Random tvalid/full toggling over 1000 beats -> scoreboard exact order, wr never with full, tready never low in EMPTY/ONE.
REQ-034 Single-beat frame then 70000-beat frame (BEAT_CNT_W=16) -> frame_beats=1, then 65535 (saturated).
REQ-035 rst_n asserted in state TWO mid-frame -> wr=0, tready=1 after release, next frame counts from 1, no stale frame_done.

Source files
------------

// File: rtl/cr_structs.sv
// Shared AXI4-Stream datapath types for the cr_* blocks.
package cr_structs;

  typedef struct packed {
    logic        tvalid;
    logic        tlast;
    logic [3:0]  tuser;
    logic [3:0]  tkeep;
    logic [31:0] tdata;
  } axi4s_su_dp_bus_t;

  typedef struct packed {
    logic tready;
  } axi4s_dp_rdy_t;

endpackage

// File: rtl/cr_axi4s_slv_su.sv
// AXI4-Stream slave with a two-entry (main + skid) buffer feeding a downstream FIFO,
// plus a per-frame saturating beat counter.
module cr_axi4s_slv_su
  import cr_structs::*;
#(
  parameter int BEAT_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  axi4s_su_dp_bus_t      axi4s_ib_in,
  output axi4s_dp_rdy_t         axi4s_ib_out,
  output logic                  axi4s_slv_wr,
  output axi4s_su_dp_bus_t      axi4s_slv_data,
  input  logic                  axi4s_slv_full,
  output logic                  frame_done,
  output logic [BEAT_CNT_W-1:0] frame_beats
);

  // Encoding chosen so bit 0 is M.valid and bit 1 is S.valid straight from the register.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b11
  } occ_e;

  occ_e             state_q, state_d;
  axi4s_su_dp_bus_t m_q, m_d;
  axi4s_su_dp_bus_t s_q, s_d;
  logic [BEAT_CNT_W-1:0] beat_cnt_q;
  logic [BEAT_CNT_W-1:0] beat_cnt_inc;
  logic             accept;
  logic             wr;

  assign axi4s_ib_out.tready = ~state_q[1];
  assign accept              = axi4s_ib_in.tvalid & ~state_q[1];
  assign wr                  = state_q[0] & ~axi4s_slv_full;
  assign axi4s_slv_wr        = wr;
  assign axi4s_slv_data      = m_q;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          m_d     = axi4s_ib_in;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept && wr) begin
          m_d = axi4s_ib_in;
        end else if (accept) begin
          s_d     = axi4s_ib_in;
          state_d = TWO;
        end else if (wr) begin
          m_d     = '0;
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (wr) begin
          m_d     = s_q;
          s_d     = '0;
          state_d = ONE;
        end
      end
      default: begin
        m_d     = '0;
        s_d     = '0;
        state_d = EMPTY;
      end
    endcase
  end

  // NOTE: the payload entries are reset too, because the data output must read zero when empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      m_q     <= '0;
      s_q     <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so all flops update together.
      state_q <= state_d;
      m_q     <= m_d;
      s_q     <= s_d;
    end
  end

  assign beat_cnt_inc = (&beat_cnt_q) ? beat_cnt_q : beat_cnt_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_q  <= '0;
      frame_done  <= 1'b0;
      frame_beats <= '0;
    end else begin
      frame_done <= 1'b0;
      if (wr) begin
        if (m_q.tlast) begin
          beat_cnt_q  <= '0;
          frame_done  <= 1'b1;
          frame_beats <= beat_cnt_inc;
        end else begin
          beat_cnt_q <= beat_cnt_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_cr_axi4s_slv_su.sv
// Randomized bench for cr_axi4s_slv_su against a queue-based model of the buffered beats.
module tb_cr_axi4s_slv_su;
  import cr_structs::*;

  localparam int BEAT_CNT_W = 16;
  localparam int SAT        = (1 << BEAT_CNT_W) - 1;

  logic                  clk;
  logic                  rst_n;
  axi4s_su_dp_bus_t      ib_in;
  axi4s_dp_rdy_t         ib_out;
  logic                  slv_wr;
  axi4s_su_dp_bus_t      slv_data;
  logic                  slv_full;
  logic                  frame_done;
  logic [BEAT_CNT_W-1:0] frame_beats;

  cr_axi4s_slv_su #(.BEAT_CNT_W(BEAT_CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .axi4s_ib_in    (ib_in),
    .axi4s_ib_out   (ib_out),
    .axi4s_slv_wr   (slv_wr),
    .axi4s_slv_data (slv_data),
    .axi4s_slv_full (slv_full),
    .frame_done     (frame_done),
    .frame_beats    (frame_beats)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model: beats accepted but not yet written, in arrival order.
  axi4s_su_dp_bus_t q[$];
  int  frame_cnt  = 0;
  bit  done_pend  = 0;
  int  beats_hold = 0;
  bit  holding    = 0;
  int  n_written  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    frame_cnt  = 0;
    done_pend  = 0;
    beats_hold = 0;
    holding    = 0;
  endtask

  // One clock: present a beat (or hold a stalled one), check outputs, advance the model.
  task automatic cycle(input bit full_in, input bit offer, input bit last_if_new);
    bit exp_wr;
    bit acc;
    axi4s_su_dp_bus_t b;
    @(negedge clk);
    if (!holding) begin
      if (offer) begin
        ib_in.tvalid = 1'b1;
        ib_in.tlast  = last_if_new;
        ib_in.tuser  = 4'($urandom);
        ib_in.tkeep  = 4'($urandom);
        ib_in.tdata  = $urandom;
      end else begin
        ib_in = '0;
      end
    end
    slv_full = full_in;
    #1;
    exp_wr = (q.size() > 0) && !full_in;
    check("tready", 64'(ib_out.tready), 64'(q.size() < 2));
    check("wr", 64'(slv_wr), 64'(exp_wr));
    check("data", 64'(slv_data), (q.size() > 0) ? 64'(q[0]) : 64'd0);
    check("frame_done", 64'(frame_done), 64'(done_pend));
    check("frame_beats", 64'(frame_beats), 64'(beats_hold));
    acc = ib_in.tvalid && (q.size() < 2);
    @(posedge clk);
    done_pend = 0;
    if (exp_wr) begin
      b = q.pop_front();
      n_written++;
      if (frame_cnt < SAT) frame_cnt++;
      if (b.tlast) begin
        done_pend  = 1;
        beats_hold = frame_cnt;
        frame_cnt  = 0;
      end
    end
    if (acc) q.push_back(ib_in);
    holding = ib_in.tvalid && !acc;
  endtask

  // Run until every buffered beat has drained, bounded.
  task automatic drain();
    int budget = 20;
    while ((q.size() > 0 || holding) && budget > 0) begin
      cycle(1'b0, 1'b0, 1'b0);
      budget--;
    end
    check("drain_timeout", 64'(q.size() + int'(holding)), 64'd0);
    cycle(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int target;
    rst_n    = 1'b0;
    ib_in    = '0;
    slv_full = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset.
    repeat (3) cycle(1'b0, 1'b0, 1'b0);

    // Back-to-back 4-beat frame, downstream never full.
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, i == 3);
    drain();
    check("frame4_beats", 64'(frame_beats), 64'd4);

    // Stall downstream while streaming: only two beats fit.
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, i == 4);
    check("skid_tready_low", 64'(ib_out.tready), 64'd0);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, i == 5);
    drain();

    // Random tvalid/full over 1000 written beats.
    target = n_written + 1000;
    for (int c = 0; c < 20000 && n_written < target; c++)
      cycle(($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 7), ($urandom_range(0, 7) == 0));
    check("random_progress", 64'(n_written >= target), 64'd1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b1);
    drain();

    // Single-beat frame, then a frame long enough to saturate the counter.
    cycle(1'b0, 1'b1, 1'b1);
    drain();
    check("single_beat", 64'(frame_beats), 64'd1);
    for (int i = 0; i < 70000; i++) cycle(1'b0, 1'b1, i == 69999);
    drain();
    check("saturated", 64'(frame_beats), 64'(SAT));

    // Reset while both entries are occupied mid-frame.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0);
    check("pre_reset_two", 64'(ib_out.tready), 64'd0);
    @(negedge clk);
    rst_n    = 1'b0;
    ib_in    = '0;
    slv_full = 1'b0;
    #1;
    check("rst_wr", 64'(slv_wr), 64'd0);
    check("rst_tready", 64'(ib_out.tready), 64'd1);
    check("rst_data", 64'(slv_data), 64'd0);
    @(posedge clk);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) cycle(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) cycle(1'b0, 1'b1, i == 1);
    drain();
    check("post_reset_frame", 64'(frame_beats), 64'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
